// File: rtl/seq_calculator.sv
// -----------------------------------------------------------------------------
// seq_calculator
//   Multi-cycle signed calculator. Add/sub/mul finish in one execute cycle.
//   Divide uses a restoring shift-subtract divider (one quotient bit per
//   cycle). Power uses LSB-first square-and-multiply over all NB bits of b.
//
//   Optional feature macro: CALC_POW_EN
//     defined   -> opcode 4 computes a**b
//     undefined -> no power datapath; opcode 4 is reported as invalid
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   start     request, sampled only while busy=0 (IDLE or FIN)
//   operand   opcode: 0 add, 1 sub, 2 mul, 3 div, 4 pow, 5-7 invalid
//   a, b      signed NB-bit operands, latched on acceptance
//   busy      high while an operation executes
//   done      one-cycle completion pulse
//   result    signed NB-bit result, held after done
//   err_div0  divide-by-zero flag, valid with done
//   err_op    invalid-opcode flag, valid with done
// -----------------------------------------------------------------------------
module seq_calculator #(
  parameter int NB = 48
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [2:0]    operand,
  input  logic [NB-1:0] a,
  input  logic [NB-1:0] b,
  output logic          busy,
  output logic          done,
  output logic [NB-1:0] result,
  output logic          err_div0,
  output logic          err_op
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
`ifdef CALC_POW_EN
  localparam logic [2:0] OP_POW = 3'd4;
`endif

  localparam int            CW   = $clog2(NB + 1);
  // Iterative ops run NB step cycles (cnt 0..NB-1) plus one finishing cycle.
  localparam logic [CW-1:0] LAST = CW'(NB);

  logic [1:0]    state_reg;
  logic [2:0]    op_reg;
  logic [NB-1:0] a_reg;
  logic [NB-1:0] b_reg;
  logic [CW-1:0] cnt_reg;
  logic [NB-1:0] res_reg;
  logic          e0_reg;
  logic          eo_reg;

  // Divider state: quo_reg starts as |a| and is shifted out MSB-first into
  // the partial remainder while quotient bits shift in at the LSB.
  logic [NB-1:0] quo_reg;
  logic [NB-1:0] dvs_reg;
  logic [NB-1:0] rem_reg;
  logic          neg_reg;

  logic [NB-1:0] a_mag;
  logic [NB-1:0] b_mag;
  logic [NB:0]   rem_shift;
  logic [NB:0]   div_trial;

  always_comb begin
    // Magnitude of the most negative value is 2^(NB-1), which still fits
    // in NB unsigned bits.
    a_mag     = a[NB-1] ? -a : a;
    b_mag     = b[NB-1] ? -b : b;
    rem_shift = {rem_reg, quo_reg[NB-1]};
    div_trial = rem_shift - {1'b0, dvs_reg};
  end

`ifdef CALC_POW_EN
  localparam logic [NB-1:0] ONE = NB'(1);

  logic [NB-1:0] acc_reg;
  logic [NB-1:0] base_reg;
  logic [NB-1:0] exp_reg;
  logic [NB-1:0] acc_mul;
  logic [NB-1:0] base_sq;

  // Only the low NB bits of each intermediate are kept, and the low half of
  // a product is the same for signed and unsigned operands.
  assign acc_mul = acc_reg * base_reg;
  assign base_sq = base_reg * base_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      res_reg   <= '0;
      e0_reg    <= 1'b0;
      eo_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, FIN: begin
          if (start) begin
            state_reg <= EXEC;
            op_reg    <= operand;
            a_reg     <= a;
            b_reg     <= b;
            cnt_reg   <= '0;
            e0_reg    <= 1'b0;
            eo_reg    <= 1'b0;
            quo_reg   <= a_mag;
            dvs_reg   <= b_mag;
            rem_reg   <= '0;
            neg_reg   <= a[NB-1] ^ b[NB-1];
`ifdef CALC_POW_EN
            acc_reg   <= ONE;
            base_reg  <= a;
            exp_reg   <= b;
`endif
          end else begin
            state_reg <= IDLE;
          end
        end

        EXEC: begin
          case (op_reg)
            OP_ADD: begin
              res_reg   <= a_reg + b_reg;
              state_reg <= FIN;
            end
            OP_SUB: begin
              res_reg   <= a_reg - b_reg;
              state_reg <= FIN;
            end
            OP_MUL: begin
              // Full 2*NB-bit signed product, then keep the low NB bits.
              res_reg   <= NB'({{NB{a_reg[NB-1]}}, a_reg} * {{NB{b_reg[NB-1]}}, b_reg});
              state_reg <= FIN;
            end
            OP_DIV: begin
              if (b_reg == '0) begin
                res_reg   <= '0;
                e0_reg    <= 1'b1;
                state_reg <= FIN;
              end else if (cnt_reg != LAST) begin
                if (!div_trial[NB]) begin
                  rem_reg <= div_trial[NB-1:0];
                  quo_reg <= {quo_reg[NB-2:0], 1'b1};
                end else begin
                  rem_reg <= rem_shift[NB-1:0];
                  quo_reg <= {quo_reg[NB-2:0], 1'b0};
                end
                cnt_reg <= cnt_reg + 1'b1;
              end else begin
                // Truncation toward zero falls out of dividing magnitudes.
                // -2^(NB-1) / -1 gives magnitude 2^(NB-1), which reads back
                // as -2^(NB-1): the intended wrap.
                res_reg   <= neg_reg ? -quo_reg : quo_reg;
                state_reg <= FIN;
              end
            end
`ifdef CALC_POW_EN
            OP_POW: begin
              if (cnt_reg != LAST) begin
                if (exp_reg[0]) begin
                  acc_reg <= acc_mul;
                end
                base_reg <= base_sq;
                exp_reg  <= {1'b0, exp_reg[NB-1:1]};
                cnt_reg  <= cnt_reg + 1'b1;
              end else begin
                // Negative exponent: only +1 and -1 have integer results.
                // For those bases the unsigned-exponent product already has
                // the right value (same parity), so it is passed through.
                if (b_reg[NB-1] && (a_reg != ONE) && (a_reg != '1)) begin
                  res_reg <= '0;
                end else begin
                  res_reg <= acc_reg;
                end
                state_reg <= FIN;
              end
            end
`endif
            default: begin
              res_reg   <= '0;
              eo_reg    <= 1'b1;
              state_reg <= FIN;
            end
          endcase
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy     = (state_reg == EXEC);
  assign done     = (state_reg == FIN);
  assign result   = res_reg;
  assign err_div0 = e0_reg;
  assign err_op   = eo_reg;

endmodule

// File: tb/tb_seq_calculator.sv
`timescale 1ns/1ps
module tb_seq_calculator;

  localparam int NB = 8;
  localparam int WB = 48;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start;
  logic [2:0]    operand;
  logic [NB-1:0] a;
  logic [NB-1:0] b;
  logic          busy;
  logic          done;
  logic [NB-1:0] result;
  logic          err_div0;
  logic          err_op;

  logic          w_start;
  logic [2:0]    w_operand;
  logic [WB-1:0] w_a;
  logic [WB-1:0] w_b;
  logic          w_busy;
  logic          w_done;
  logic [WB-1:0] w_result;
  logic          w_err_div0;
  logic          w_err_op;

  seq_calculator #(.NB(NB)) dut (
    .clk(clk), .rst(rst), .start(start), .operand(operand), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .err_div0(err_div0), .err_op(err_op)
  );

  seq_calculator #(.NB(WB)) dut_wide (
    .clk(clk), .rst(rst), .start(w_start), .operand(w_operand), .a(w_a), .b(w_b),
    .busy(w_busy), .done(w_done), .result(w_result), .err_div0(w_err_div0), .err_op(w_err_op)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [NB-1:0] res;
    bit            e0;
    bit            eo;
    int            lat;
  } exp_t;

  exp_t sb[$];

  localparam logic signed [NB-1:0] P1 = NB'(1);
  localparam logic signed [NB-1:0] M1 = NB'(-1);

  // Reference model: plain arithmetic on wide integers, then truncation.
  function automatic exp_t model(input logic [2:0] op, input logic signed [NB-1:0] x,
                                 input logic signed [NB-1:0] y);
    exp_t e;
    longint q;
    logic signed [NB-1:0] acc;
    e.res = '0; e.e0 = 1'b0; e.eo = 1'b0; e.lat = 1;
    case (op)
      3'd0: e.res = x + y;
      3'd1: e.res = x - y;
      3'd2: e.res = x * y;
      3'd3: begin
        if (y == '0) e.e0 = 1'b1;
        else begin
          q = longint'(x) / longint'(y);
          e.res = q[NB-1:0];
          e.lat = NB + 1;
        end
      end
`ifdef CALC_POW_EN
      3'd4: begin
        e.lat = NB + 1;
        if (y[NB-1]) begin
          if (x == P1) e.res = P1;
          else if (x == M1) e.res = y[0] ? M1 : P1;
        end else begin
          acc = P1;
          for (int i = 0; i < int'(y); i++) acc = acc * x;
          e.res = acc;
        end
      end
`endif
      default: e.eo = 1'b1;
    endcase
    return e;
  endfunction

  // Drive one start pulse (accepted at the next edge) and record the expectation.
  task automatic issue(input logic [2:0] op, input logic [NB-1:0] x, input logic [NB-1:0] y);
    sb.push_back(model(op, x, y));
    operand = op; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; operand = 3'($urandom); a = NB'($urandom); b = NB'($urandom);
  endtask

  // Count edges after acceptance until done is seen (bounded).
  task automatic collect(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (done !== 1'b1 && lat < 200);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; operand = '0; a = '0; b = '0;
    w_start = 1'b0; w_operand = '0; w_a = '0; w_b = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (result !== '0) begin n_fail++; $display("FAIL reset_result: got %h want 0", result); end
    n_cmp++; if ({err_div0, err_op} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {err_div0, err_op}); end
    n_cmp++; if ({w_busy, w_done} !== 2'b00) begin n_fail++; $display("FAIL reset_wide: got %b want 00", {w_busy, w_done}); end
    $display("reset: outputs checked");
    rst = 1'b0;
  endtask

  task automatic test_wide();
    logic [2:0] wo[3] = '{3'd0, 3'd1, 3'd2};
    longint wx[3] = '{-5, 3, -3};
    longint wy[3] = '{12, 10, 9};
    longint wr[3] = '{7, -7, -27};
    int lat;
    for (int i = 0; i < 3; i++) begin
      w_operand = wo[i]; w_a = WB'(wx[i]); w_b = WB'(wy[i]); w_start = 1'b1;
      @(posedge clk); #1;
      w_start = 1'b0; w_a = '0; w_b = '0;
      lat = 0;
      do begin @(posedge clk); #1; lat++; end while (w_done !== 1'b1 && lat < 200);
      $display("wide op=%0d a=%0d b=%0d -> result=%0d lat=%0d", wo[i], wx[i], wy[i], $signed(w_result), lat);
      n_cmp++; if (lat != 1) begin n_fail++; $display("FAIL wide_lat[%0d]: got %0d want 1", i, lat); end
      n_cmp++; if (w_result !== WB'(wr[i])) begin n_fail++; $display("FAIL wide_result[%0d]: got %0d want %0d", i, $signed(w_result), wr[i]); end
      n_cmp++; if ({w_err_div0, w_err_op} !== 2'b00) begin n_fail++; $display("FAIL wide_flags[%0d]: got %b want 00", i, {w_err_div0, w_err_op}); end
    end
  endtask

  task automatic test_arith();
    logic [2:0] ops[10] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd0, 3'd1, 3'd0, 3'd1, 3'd2, 3'd2};
    int xs[10] = '{-5, 3, -3, 100, 127, -128, 0, 0, 0, 0};
    int ys[10] = '{12, 10, 9, 3, 1, 1, 0, 0, 0, 0};
    logic [NB-1:0] x, y;
    exp_t e;
    int lat;
    for (int i = 0; i < 10; i++) begin
      if (i < 6) begin x = NB'(xs[i]); y = NB'(ys[i]); end
      else begin x = NB'($urandom); y = NB'($urandom); end
      issue(ops[i], x, y);
      collect(lat);
      e = sb.pop_front();
      $display("arith op=%0d a=%0d b=%0d -> result=%0d lat=%0d", ops[i], $signed(x), $signed(y), $signed(result), lat);
      n_cmp++; if (lat != e.lat) begin n_fail++; $display("FAIL arith_lat[%0d]: got %0d want %0d", i, lat, e.lat); end
      n_cmp++; if (result !== e.res) begin n_fail++; $display("FAIL arith_result[%0d]: got %h want %h", i, result, e.res); end
      n_cmp++; if ({err_div0, err_op} !== {e.e0, e.eo}) begin n_fail++; $display("FAIL arith_flags[%0d]: got %b want %b", i, {err_div0, err_op}, {e.e0, e.eo}); end
    end
  endtask

  task automatic test_div();
    int xs[8] = '{-100, -128, 127, -7, 1, 0, 0, 0};
    int ys[8] = '{7, -1, -3, 2, -128, 1, 1, 1};
    logic [NB-1:0] x, y;
    exp_t e;
    int lat;
    for (int i = 0; i < 8; i++) begin
      if (i < 5) begin x = NB'(xs[i]); y = NB'(ys[i]); end
      else begin x = NB'($urandom); y = NB'($urandom_range(1, 255)); end
      issue(3'd3, x, y);
      if (i == 0) begin
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL div_busy: got %b want 1", busy); end
      end
      collect(lat);
      e = sb.pop_front();
      $display("div a=%0d b=%0d -> result=%0d lat=%0d", $signed(x), $signed(y), $signed(result), lat);
      n_cmp++; if (lat != e.lat) begin n_fail++; $display("FAIL div_lat[%0d]: got %0d want %0d", i, lat, e.lat); end
      n_cmp++; if (result !== e.res) begin n_fail++; $display("FAIL div_result[%0d]: got %h want %h", i, result, e.res); end
      n_cmp++; if ({err_div0, err_op} !== {e.e0, e.eo}) begin n_fail++; $display("FAIL div_flags[%0d]: got %b want %b", i, {err_div0, err_op}, {e.e0, e.eo}); end
    end
  endtask

  task automatic test_errors();
    logic [2:0] ops[7] = '{3'd3, 3'd0, 3'd6, 3'd5, 3'd7, 3'd1, 3'd4};
    int xs[7] = '{55, 1, 9, 9, 9, 4, 3};
    int ys[7] = '{0, 1, 9, 9, 9, 6, 4};
    exp_t e;
    int lat;
    for (int i = 0; i < 7; i++) begin
      issue(ops[i], NB'(xs[i]), NB'(ys[i]));
      collect(lat);
      e = sb.pop_front();
      $display("errors op=%0d a=%0d b=%0d -> result=%0d div0=%b op=%b lat=%0d", ops[i], xs[i], ys[i], $signed(result), err_div0, err_op, lat);
      n_cmp++; if (lat != e.lat) begin n_fail++; $display("FAIL err_lat[%0d]: got %0d want %0d", i, lat, e.lat); end
      n_cmp++; if (result !== e.res) begin n_fail++; $display("FAIL err_result[%0d]: got %h want %h", i, result, e.res); end
      n_cmp++; if ({err_div0, err_op} !== {e.e0, e.eo}) begin n_fail++; $display("FAIL err_flags[%0d]: got %b want %b", i, {err_div0, err_op}, {e.e0, e.eo}); end
    end
  endtask

  task automatic test_pow();
    int xs[8] = '{3, -1, 2, 3, 5, 2, 1, -1};
    int ys[8] = '{4, -3, 10, 5, 0, -1, -5, -4};
    exp_t e;
    int lat;
    for (int i = 0; i < 8; i++) begin
      issue(3'd4, NB'(xs[i]), NB'(ys[i]));
      collect(lat);
      e = sb.pop_front();
      $display("pow a=%0d b=%0d -> result=%0d err_op=%b lat=%0d", xs[i], ys[i], $signed(result), err_op, lat);
      n_cmp++; if (lat != e.lat) begin n_fail++; $display("FAIL pow_lat[%0d]: got %0d want %0d", i, lat, e.lat); end
      n_cmp++; if (result !== e.res) begin n_fail++; $display("FAIL pow_result[%0d]: got %h want %h", i, result, e.res); end
      n_cmp++; if ({err_div0, err_op} !== {e.e0, e.eo}) begin n_fail++; $display("FAIL pow_flags[%0d]: got %b want %b", i, {err_div0, err_op}, {e.e0, e.eo}); end
    end
  endtask

  // Starts pulsed at E3 and E5 of a running divide must be ignored.
  task automatic test_ignore();
    exp_t e;
    int ndone = 0;
    int first = 0;
    logic [NB-1:0] got = '0;
    issue(3'd3, NB'(-100), NB'(7));
    for (int cyc = 1; cyc <= 30; cyc++) begin
      start = (cyc == 3 || cyc == 5); operand = 3'd0; a = NB'(1); b = NB'(1);
      @(posedge clk); #1;
      start = 1'b0;
      if (done === 1'b1) begin
        ndone++;
        if (first == 0) begin first = cyc; got = result; end
      end
    end
    e = sb.pop_front();
    $display("ignore: dones=%0d first=%0d result=%0d", ndone, first, $signed(got));
    n_cmp++; if (ndone != 1) begin n_fail++; $display("FAIL ignore_count: got %0d want 1", ndone); end
    n_cmp++; if (first != e.lat) begin n_fail++; $display("FAIL ignore_lat: got %0d want %0d", first, e.lat); end
    n_cmp++; if (got !== e.res) begin n_fail++; $display("FAIL ignore_result: got %h want %h", got, e.res); end
  endtask

  // Start held high through FIN: the next op is accepted on the edge after done.
  task automatic test_back_to_back();
    exp_t e;
    int lat;
    sb.push_back(model(3'd0, NB'(20), NB'(22)));
    sb.push_back(model(3'd2, NB'(-4), NB'(6)));
    operand = 3'd0; a = NB'(20); b = NB'(22); start = 1'b1;
    @(posedge clk); #1;
    operand = 3'd2; a = NB'(-4); b = NB'(6);
    @(posedge clk); #1;
    e = sb.pop_front();
    $display("b2b first: done=%b result=%0d", done, $signed(result));
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done1: got %b want 1", done); end
    n_cmp++; if (result !== e.res) begin n_fail++; $display("FAIL b2b_result1: got %h want %h", result, e.res); end
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++; if ({busy, done} !== 2'b10) begin n_fail++; $display("FAIL b2b_accept: got busy,done=%b want 10", {busy, done}); end
    collect(lat);
    e = sb.pop_front();
    $display("b2b second: result=%0d lat=%0d", $signed(result), lat);
    n_cmp++; if (lat != e.lat) begin n_fail++; $display("FAIL b2b_lat2: got %0d want %0d", lat, e.lat); end
    n_cmp++; if (result !== e.res) begin n_fail++; $display("FAIL b2b_result2: got %h want %h", result, e.res); end
  endtask

  // Reset during a divide abandons it; a start right after reset is accepted.
  task automatic test_rst_mid();
    exp_t e;
    int lat;
    int ndone = 0;
    issue(3'd3, NB'(-100), NB'(7));
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    sb.delete();
    $display("rst_mid: busy=%b done=%b result=%h flags=%b", busy, done, result, {err_div0, err_op});
    n_cmp++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL rstmid_ctrl: got %b want 00", {busy, done}); end
    n_cmp++; if (result !== '0) begin n_fail++; $display("FAIL rstmid_result: got %h want 0", result); end
    n_cmp++; if ({err_div0, err_op} !== 2'b00) begin n_fail++; $display("FAIL rstmid_flags: got %b want 00", {err_div0, err_op}); end
    rst = 1'b0;
    issue(3'd2, NB'(-3), NB'(9));
    collect(lat);
    e = sb.pop_front();
    $display("rst_mid mul: result=%0d lat=%0d", $signed(result), lat);
    n_cmp++; if (lat != e.lat) begin n_fail++; $display("FAIL rstmid_lat: got %0d want %0d", lat, e.lat); end
    n_cmp++; if (result !== e.res) begin n_fail++; $display("FAIL rstmid_mul: got %h want %h", result, e.res); end
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(posedge clk); #1;
      if (done === 1'b1) ndone++;
    end
    n_cmp++; if (ndone != 0) begin n_fail++; $display("FAIL rstmid_stray_done: got %0d want 0", ndone); end
  endtask

  initial begin
    test_reset();
    test_wide();
    test_arith();
    test_div();
    test_errors();
    test_pow();
    test_ignore();
    test_back_to_back();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
